lock_sequencer: RTL and testbench

Supervisory FSM for the keypad password lock; sits beside the password register and observes its correct and error_count outputs. Owns unlock timing, failed-attempt accounting, lockout, alarm and entry timeout. Clears the password register through its active-low reset and gates the keypad path via key_enable. Keeps its own failure and lockout counters, because clearing the register also zeroes the register's error count.

---
 rtl/lock_sequencer.sv | 165 ++++++++++++++++
 tb/tb_lock_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// Supervisory FSM for the keypad password lock: unlock timing, failed-attempt
// accounting, lockout, alarm and entry timeout around the password register.
module lock_sequencer #(
  parameter int UNLOCK_CYCLES  = 100,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int MAX_TRIES      = 3,
  parameter int MAX_LOCKOUTS   = 2,
  parameter int CNT_W          = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_valid,
  input  logic       correct,
  input  logic [3:0] error_count,
  input  logic       clear_alarm,
  output logic       reg_rstn,
  output logic       key_enable,
  output logic       unlock,
  output logic       locked,
  output logic       alarm,
  output logic [3:0] fail_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_CLR      = 3'd3,
    S_LOCKOUT  = 3'd4,
    S_ALARM    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] L_UNLOCK_END = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_LOCK_END   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TMO_END    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       L_MAX_TRIES  = 5'(MAX_TRIES);
  localparam logic [3:0]       L_MAX_LOCKS  = 4'(MAX_LOCKOUTS);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nx;
  logic [CNT_W-1:0] w_timer_inc;
  logic [3:0]       r_fail;
  logic [3:0]       w_fail_nx;
  logic [3:0]       r_lock;
  logic [3:0]       w_lock_nx;
  logic [3:0]       w_lock_inc;
  logic [4:0]       w_fail_inc;
  logic             r_prev_correct;
  logic [3:0]       r_prev_err;
  logic             w_corr_evt;
  logic             w_err_evt;

  // A drop to zero comes from a clear, never from a wrong entry
  assign w_corr_evt = correct & ~r_prev_correct;
  assign w_err_evt  = (error_count != r_prev_err) && (error_count != 4'd0);

  assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;
  assign w_fail_inc  = {1'b0, r_fail} + 5'd1;
  assign w_lock_inc  = (&r_lock) ? r_lock : r_lock + 4'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_fail         <= 4'd0;
      r_lock         <= 4'd0;
      r_prev_correct <= 1'b0;
      r_prev_err     <= 4'd0;
    end else begin
      r_state        <= w_state_nx;
      r_timer        <= w_timer_nx;
      r_fail         <= w_fail_nx;
      r_lock         <= w_lock_nx;
      r_prev_correct <= correct;
      r_prev_err     <= error_count;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = w_timer_inc;
    w_fail_nx  = r_fail;
    w_lock_nx  = r_lock;
    unique case (r_state)
      S_IDLE, S_ENTRY: begin
        if (w_corr_evt) begin
          w_state_nx = S_UNLOCKED;
          w_fail_nx  = 4'd0;
          w_lock_nx  = 4'd0;
        end else if (w_err_evt) begin
          w_timer_nx = '0;
          if (w_fail_inc < L_MAX_TRIES) begin
            w_fail_nx  = w_fail_inc[3:0];
            w_state_nx = S_ENTRY;
          end else begin
            w_fail_nx  = 4'd0;
            w_lock_nx  = w_lock_inc;
            w_state_nx = S_LOCKOUT;
          end
        end else if (key_valid) begin
          w_state_nx = S_ENTRY;
          w_timer_nx = '0;
        end else if (r_state == S_ENTRY) begin
          if (r_timer == L_TMO_END) begin
            w_state_nx = S_CLR;
            w_fail_nx  = 4'd0;
          end
        end else begin
          w_timer_nx = r_timer;
        end
      end
      S_UNLOCKED: begin
        if (r_timer == L_UNLOCK_END) w_state_nx = S_CLR;
      end
      S_CLR: begin
        w_state_nx = S_IDLE;
      end
      S_LOCKOUT: begin
        if (r_timer == L_LOCK_END)
          w_state_nx = (r_lock == L_MAX_LOCKS) ? S_ALARM : S_IDLE;
      end
      S_ALARM: begin
        if (clear_alarm) begin
          w_state_nx = S_IDLE;
          w_fail_nx  = 4'd0;
          w_lock_nx  = 4'd0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    if (w_state_nx != r_state) w_timer_nx = '0;
  end

  always_comb begin
    key_enable = 1'b0;
    unlock     = 1'b0;
    locked     = 1'b0;
    alarm      = 1'b0;
    reg_rstn   = ~RST;
    unique case (r_state)
      S_IDLE, S_ENTRY: key_enable = 1'b1;
      S_UNLOCKED:      unlock     = 1'b1;
      S_CLR:           reg_rstn   = 1'b0;
      S_LOCKOUT: begin
        locked   = 1'b1;
        reg_rstn = 1'b0;
      end
      S_ALARM: begin
        alarm    = 1'b1;
        reg_rstn = 1'b0;
      end
      default: key_enable = 1'b0;
    endcase
  end

  assign fail_cnt = r_fail;
  assign state    = r_state;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer with a cycle-level behavioural model
// (countdown-based) compared every cycle plus literal spot checks.
module tb_lock_sequencer;

  localparam int UNL   = 4;
  localparam int LCK   = 8;
  localparam int TMO   = 6;
  localparam int TRIES = 3;
  localparam int LOCKS = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       key_valid = 1'b0;
  logic       correct = 1'b0;
  logic [3:0] error_count = 4'd0;
  logic       clear_alarm = 1'b0;
  logic       reg_rstn;
  logic       key_enable;
  logic       unlock;
  logic       locked;
  logic       alarm;
  logic [3:0] fail_cnt;
  logic [2:0] state;

  always #5 CLK = ~CLK;

  lock_sequencer #(
    .UNLOCK_CYCLES (UNL),
    .LOCK_CYCLES   (LCK),
    .TIMEOUT_CYCLES(TMO),
    .MAX_TRIES     (TRIES),
    .MAX_LOCKOUTS  (LOCKS),
    .CNT_W         (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .key_valid  (key_valid),
    .correct    (correct),
    .error_count(error_count),
    .clear_alarm(clear_alarm),
    .reg_rstn   (reg_rstn),
    .key_enable (key_enable),
    .unlock     (unlock),
    .locked     (locked),
    .alarm      (alarm),
    .fail_cnt   (fail_cnt),
    .state      (state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  // model: mode numbers are the externally visible state codes
  int m_mode  = 0;
  int m_left  = 0;
  int m_idle  = 0;
  int m_fail  = 0;
  int m_locks = 0;
  int m_pe    = 0;
  bit m_pc    = 0;

  task automatic model_step();
    bit ce;
    bit ee;
    if (RST) begin
      m_mode = 0; m_left = 0; m_idle = 0;
      m_fail = 0; m_locks = 0; m_pc = 0; m_pe = 0;
      return;
    end
    ce = correct && !m_pc;
    ee = (int'(error_count) != m_pe) && (error_count != 0);
    case (m_mode)
      0, 1: begin
        if (ce) begin
          m_mode = 2; m_left = UNL; m_fail = 0; m_locks = 0;
        end else if (ee) begin
          if (m_fail + 1 < TRIES) begin
            m_fail++; m_mode = 1; m_idle = TMO;
          end else begin
            m_fail = 0; m_mode = 4; m_left = LCK;
            m_locks = (m_locks < 15) ? m_locks + 1 : 15;
          end
        end else if (key_valid) begin
          m_mode = 1; m_idle = TMO;
        end else if (m_mode == 1) begin
          m_idle--;
          if (m_idle == 0) begin m_mode = 3; m_fail = 0; end
        end
      end
      2: begin m_left--; if (m_left == 0) m_mode = 3; end
      3: m_mode = 0;
      4: begin
        m_left--;
        if (m_left == 0) m_mode = (m_locks >= LOCKS) ? 5 : 0;
      end
      5: if (clear_alarm) begin m_mode = 0; m_fail = 0; m_locks = 0; end
      default: m_mode = 0;
    endcase
    m_pc = correct;
    m_pe = int'(error_count);
  endtask

  task automatic compare_cycle();
    logic [11:0] got;
    logic [11:0] exp;
    bit rst_hold;
    rst_hold = (m_mode == 3) || (m_mode == 4) || (m_mode == 5);
    got = {state, fail_cnt, key_enable, unlock, locked, alarm, reg_rstn};
    exp = {3'(m_mode), 4'(m_fail), m_mode <= 1, m_mode == 2,
           m_mode == 4, m_mode == 5, !RST && !rst_hold};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cycle t=%0t got=%h expected=%h", $time, got, exp);
    end
  endtask

  task automatic check(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(negedge CLK);
      #2;
    end
  endtask

  task automatic pulse_key();
    key_valid = 1'b1; cyc(); key_valid = 1'b0;
  endtask

  task automatic do_lockout();
    for (int e = 1; e <= 3; e++) begin
      error_count = 4'(e); cyc();
    end
    error_count = 4'd0;
    cyc(LCK);
  endtask

  task automatic stimulus();
    int n;
    cyc(3);
    cmp_en = 1;
    check("rst_state", int'(state), 0);
    check("rst_keyen", int'(key_enable), 1);
    check("rst_rstn", int'(reg_rstn), 0);
    check("rst_fail", int'(fail_cnt), 0);
    RST = 1'b0; cyc();
    check("rstn_release", int'(reg_rstn), 1);

    // correct entry, key ignored while unlocked
    pulse_key();
    check("t1_entry", int'(state), 1);
    correct = 1'b1; cyc();
    check("t1_unlock", int'(unlock), 1);
    pulse_key();
    check("t1_key_ignored", int'(state), 2);
    n = 2;
    while (unlock === 1'b1 && n < 20) begin
      cyc();
      if (unlock === 1'b1) n++;
    end
    check("t1_unlock_len", n, 4);
    check("t1_clr_state", int'(state), 3);
    check("t1_clr_rstn", int'(reg_rstn), 0);
    correct = 1'b0; cyc();
    check("t1_idle", int'(state), 0);

    // three failures -> lockout
    error_count = 4'd1; cyc();
    check("t2_fail1", int'(fail_cnt), 1);
    error_count = 4'd2; cyc();
    check("t2_fail2", int'(fail_cnt), 2);
    error_count = 4'd3; cyc();
    check("t2_lockout", int'(state), 4);
    check("t2_keyen", int'(key_enable), 0);
    check("t2_fail0", int'(fail_cnt), 0);
    error_count = 4'd0;
    n = 1;
    while (locked === 1'b1 && n < 30) begin
      cyc();
      if (locked === 1'b1) n++;
    end
    check("t2_lock_len", n, 8);
    check("t2_idle", int'(state), 0);

    // second lockout -> alarm
    do_lockout();
    check("t3_alarm_state", int'(state), 5);
    cyc(5);
    check("t3_alarm_held", int'(alarm), 1);
    clear_alarm = 1'b1; cyc(); clear_alarm = 1'b0;
    check("t3_cleared", int'(state), 0);
    do_lockout();
    check("t3_one_more", int'(state), 0);
    do_lockout();
    check("t3_alarm_again", int'(state), 5);
    clear_alarm = 1'b1; cyc(); clear_alarm = 1'b0;
    check("t3_cleared2", int'(alarm), 0);

    // entry timeout and restart
    pulse_key();
    error_count = 4'd1; cyc();
    check("t4_fail1", int'(fail_cnt), 1);
    cyc(5);
    check("t4_still_entry", int'(state), 1);
    cyc();
    check("t4_clr", int'(state), 3);
    check("t4_fail0", int'(fail_cnt), 0);
    error_count = 4'd0; cyc();
    check("t4_idle", int'(state), 0);
    pulse_key();
    cyc(4);
    pulse_key();
    cyc(5);
    check("t4_restart_hold", int'(state), 1);
    cyc();
    check("t4_restart_clr", int'(state), 3);
    cyc();

    // clear artefact 2->0 during CLR
    error_count = 4'd1; cyc();
    error_count = 4'd2; cyc();
    check("t5_fail2", int'(fail_cnt), 2);
    correct = 1'b1; cyc();
    check("t5_unlocked", int'(state), 2);
    check("t5_fail_reset", int'(fail_cnt), 0);
    cyc(4);
    check("t5_clr", int'(state), 3);
    error_count = 4'd0; correct = 1'b0; cyc();
    cyc();
    check("t5_no_fail", int'(fail_cnt), 0);
    check("t5_idle", int'(state), 0);

    // reset in the middle of a lockout
    for (int e = 1; e <= 3; e++) begin
      error_count = 4'(e); cyc();
    end
    error_count = 4'd0;
    cyc(3);
    check("t6_in_lockout", int'(state), 4);
    RST = 1'b1; #1;
    check("t6_rstn_comb", int'(reg_rstn), 0);
    cyc();
    check("t6_state", int'(state), 0);
    check("t6_locked", int'(locked), 0);
    RST = 1'b0; cyc();
    check("t6_rstn", int'(reg_rstn), 1);
    do_lockout();
    check("t6_cnt_cleared", int'(state), 0);
    cyc(2);
  endtask

  initial begin
    fork
      stimulus();
      forever begin
        @(posedge CLK);
        model_step();
      end
      forever begin
        @(negedge CLK);
        if (cmp_en) compare_cycle();
      end
      begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: stimulus did not finish by t=%0t", $time);
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
